// File: rtl/regfile_op_sequencer_pkg.sv
// regfile_seq_pkg: shared types and default widths for the register-file
// operation sequencer and its command/response interface.
package regfile_seq_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_REG_WIDTH  = 8;
  localparam int DEF_OP_WIDTH   = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    EXEC  = 3'd2,
    WRITE = 3'd3,
    CLEAR = 3'd4,
    RESP  = 3'd5
  } state_t;

endpackage

// File: rtl/regfile_op_sequencer_if.sv
// regfile_op_sequencer_if: command and response handshakes of the sequencer.
// The master issues commands and consumes responses; the slave is the sequencer.
interface regfile_op_sequencer_if
  import regfile_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int REG_WIDTH  = DEF_REG_WIDTH,
  parameter int OP_WIDTH   = DEF_OP_WIDTH
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_clr;
  logic [OP_WIDTH-1:0]   cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_rs1;
  logic [ADDR_WIDTH-1:0] cmd_rs2;
  logic [ADDR_WIDTH-1:0] cmd_rd;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [REG_WIDTH-1:0]  rsp_data;
  logic [ADDR_WIDTH-1:0] rsp_rd;

  modport master (
    output cmd_valid, cmd_clr, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_rd
  );

  modport slave (
    input  cmd_valid, cmd_clr, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_rd
  );

endinterface

// File: rtl/regfile_op_sequencer.sv
// regfile_op_sequencer: runs one register-file/ALU operation per command
// (read both sources, execute, write back, respond) or clears every register,
// one per cycle. Owns both RF read ports and the single RF write port.
// Optional feature macro RF_ZERO_REG_EN: register 0 reads as zero and is
// never written by an operation (CLEAR still writes it).
module regfile_op_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int REG_WIDTH  = DEF_REG_WIDTH,
  parameter int OP_WIDTH   = DEF_OP_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_op_sequencer_if.slave bus,
  output logic [ADDR_WIDTH-1:0] rf_read_1_addr,
  output logic [ADDR_WIDTH-1:0] rf_read_2_addr,
  input  logic [REG_WIDTH-1:0]  rf_read_bus_1,
  input  logic [REG_WIDTH-1:0]  rf_read_bus_2,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [REG_WIDTH-1:0]  rf_write_bus,
  output logic                  rf_write_enabled,
  output logic [OP_WIDTH-1:0]   alu_op,
  output logic [REG_WIDTH-1:0]  alu_a,
  output logic [REG_WIDTH-1:0]  alu_b,
  input  logic [REG_WIDTH-1:0]  alu_result
);

  // Highest register index (REG_N-1); the clear sweep ends after writing it.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  state_t                state_reg, state_next;
  logic [OP_WIDTH-1:0]   op_reg;
  logic [ADDR_WIDTH-1:0] rs1_reg;
  logic [ADDR_WIDTH-1:0] rs2_reg;
  logic [ADDR_WIDTH-1:0] rd_reg;
  logic [REG_WIDTH-1:0]  opa_reg;
  logic [REG_WIDTH-1:0]  opb_reg;
  logic [REG_WIDTH-1:0]  result_reg;
  logic [ADDR_WIDTH-1:0] cnt_reg;

  logic [REG_WIDTH-1:0]  rd1_val;
  logic [REG_WIDTH-1:0]  rd2_val;
  logic                  wr_allowed;

`ifdef RF_ZERO_REG_EN
  // Register 0 is hardwired to zero: mask its read data, suppress its writes.
  assign rd1_val    = (rs1_reg == '0) ? '0 : rf_read_bus_1;
  assign rd2_val    = (rs2_reg == '0) ? '0 : rf_read_bus_2;
  assign wr_allowed = (rd_reg != '0);
`else
  assign rd1_val    = rf_read_bus_1;
  assign rd2_val    = rf_read_bus_2;
  assign wr_allowed = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.cmd_valid) state_next = bus.cmd_clr ? CLEAR : READ;
      READ:    state_next = EXEC;
      EXEC:    state_next = WRITE;
      WRITE:   state_next = RESP;
      CLEAR:   if (cnt_reg == LAST_ADDR) state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode; the write strobe depends on state only, so it drops the
  // instant reset asserts.
  always_comb begin
    rf_read_1_addr   = '0;
    rf_read_2_addr   = '0;
    rf_write_addr    = '0;
    rf_write_bus     = '0;
    rf_write_enabled = 1'b0;
    alu_op           = '0;
    alu_a            = '0;
    alu_b            = '0;
    case (state_reg)
      READ: begin
        rf_read_1_addr = rs1_reg;
        rf_read_2_addr = rs2_reg;
      end
      EXEC: begin
        alu_op = op_reg;
        alu_a  = opa_reg;
        alu_b  = opb_reg;
      end
      WRITE: begin
        rf_write_enabled = wr_allowed;
        rf_write_addr    = rd_reg;
        rf_write_bus     = result_reg;
      end
      CLEAR: begin
        rf_write_enabled = 1'b1;
        rf_write_addr    = cnt_reg;
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready = (state_reg == IDLE);
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_data  = result_reg;
  assign bus.rsp_rd    = rd_reg;

  // Command latch, operand/result capture and clear counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_reg     <= '0;
      rs1_reg    <= '0;
      rs2_reg    <= '0;
      rd_reg     <= '0;
      opa_reg    <= '0;
      opb_reg    <= '0;
      result_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_reg  <= bus.cmd_op;
            rs1_reg <= bus.cmd_rs1;
            rs2_reg <= bus.cmd_rs2;
            rd_reg  <= bus.cmd_rd;
            cnt_reg <= '0;
          end
        end
        READ: begin
          opa_reg <= rd1_val;
          opb_reg <= rd2_val;
        end
        EXEC: result_reg <= alu_result;
        CLEAR: begin
          if (cnt_reg == LAST_ADDR) begin
            // Clear reports the last register swept with a zero result.
            result_reg <= '0;
            rd_reg     <= LAST_ADDR;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// tb_regfile_op_sequencer: directed bench with a behavioural register file and
// ALU (op 0 = add, op 1 = xor, op 2 = and) around the sequencer.
module tb_regfile_op_sequencer;

  logic       clk;
  logic       reset;
  logic [4:0] rf_read_1_addr, rf_read_2_addr, rf_write_addr;
  logic [7:0] rf_read_bus_1, rf_read_bus_2, rf_write_bus;
  logic       rf_write_enabled;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_result;

  logic [7:0] regs [0:31];
  logic       pl_all, pl_one;
  logic [4:0] pl_addr;
  logic [7:0] pl_data;

  int checks = 0;
  int errors = 0;

  regfile_op_sequencer_if #(.ADDR_WIDTH(5), .REG_WIDTH(8), .OP_WIDTH(3)) sif ();

  regfile_op_sequencer #(.ADDR_WIDTH(5), .REG_WIDTH(8), .OP_WIDTH(3)) dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (sif),
    .rf_read_1_addr   (rf_read_1_addr),
    .rf_read_2_addr   (rf_read_2_addr),
    .rf_read_bus_1    (rf_read_bus_1),
    .rf_read_bus_2    (rf_read_bus_2),
    .rf_write_addr    (rf_write_addr),
    .rf_write_bus     (rf_write_bus),
    .rf_write_enabled (rf_write_enabled),
    .alu_op           (alu_op),
    .alu_a            (alu_a),
    .alu_b            (alu_b),
    .alu_result       (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model with combinational reads and a bench preload path.
  assign rf_read_bus_1 = regs[rf_read_1_addr];
  assign rf_read_bus_2 = regs[rf_read_2_addr];
  always @(posedge clk) begin
    if (pl_all) begin
      for (int i = 0; i < 32; i++) regs[i] <= pl_data;
    end else if (pl_one) begin
      regs[pl_addr] <= pl_data;
    end else if (rf_write_enabled) begin
      regs[rf_write_addr] <= rf_write_bus;
    end
  end

  // ALU model.
  always_comb begin
    case (alu_op)
      3'd0:    alu_result = alu_a + alu_b;
      3'd1:    alu_result = alu_a ^ alu_b;
      3'd2:    alu_result = alu_a & alu_b;
      default: alu_result = 8'h00;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [7:0] d);
    pl_one  = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_one  = 1'b0;
  endtask

  // One full operation with cycle-by-cycle checks; hold = cycles rsp_ready stays low.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [7:0] ea,
                       input logic [7:0] eb, input logic [7:0] er, input logic ewe,
                       input int hold);
    $display("txn %s: op=%0d rs1=%0d rs2=%0d rd=%0d expect=0x%02h write=%0d hold=%0d",
             tag, op, rs1, rs2, rd, er, ewe, hold);
    chk({tag, ".idle_ready"}, 32'(sif.cmd_ready), 32'd1);
    sif.rsp_ready = (hold == 0);
    sif.cmd_valid = 1'b1;
    sif.cmd_clr   = 1'b0;
    sif.cmd_op    = op;
    sif.cmd_rs1   = rs1;
    sif.cmd_rs2   = rs2;
    sif.cmd_rd    = rd;
    tick();
    sif.cmd_valid = 1'b0;
    // cycle 1: READ
    chk({tag, ".rd1_addr"}, 32'(rf_read_1_addr), 32'(rs1));
    chk({tag, ".rd2_addr"}, 32'(rf_read_2_addr), 32'(rs2));
    chk({tag, ".busy"}, 32'(sif.cmd_ready), 32'd0);
    tick();
    // cycle 2: EXEC
    chk({tag, ".alu_op"}, 32'(alu_op), 32'(op));
    chk({tag, ".alu_a"}, 32'(alu_a), 32'(ea));
    chk({tag, ".alu_b"}, 32'(alu_b), 32'(eb));
    chk({tag, ".no_we_exec"}, 32'(rf_write_enabled), 32'd0);
    tick();
    // cycle 3: WRITE
    chk({tag, ".we"}, 32'(rf_write_enabled), 32'(ewe));
    if (ewe) begin
      chk({tag, ".wr_addr"}, 32'(rf_write_addr), 32'(rd));
      chk({tag, ".wr_data"}, 32'(rf_write_bus), 32'(er));
    end
    tick();
    // cycle 4: RESP
    chk({tag, ".rsp_valid"}, 32'(sif.rsp_valid), 32'd1);
    chk({tag, ".rsp_data"}, 32'(sif.rsp_data), 32'(er));
    chk({tag, ".rsp_rd"}, 32'(sif.rsp_rd), 32'(rd));
    if (ewe) chk({tag, ".reg_rd"}, 32'(regs[rd]), 32'(er));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, ".hold_valid"}, 32'(sif.rsp_valid), 32'd1);
      chk({tag, ".hold_data"}, 32'(sif.rsp_data), 32'(er));
      chk({tag, ".hold_busy"}, 32'(sif.cmd_ready), 32'd0);
      chk({tag, ".hold_no_we"}, 32'(rf_write_enabled), 32'd0);
    end
    sif.rsp_ready = 1'b1;
    tick();
    chk({tag, ".back_idle"}, 32'(sif.cmd_ready), 32'd1);
    chk({tag, ".rsp_done"}, 32'(sif.rsp_valid), 32'd0);
  endtask

  initial begin
    int nz;
    reset         = 1'b0;
    sif.cmd_valid = 1'b0;
    sif.cmd_clr   = 1'b0;
    sif.cmd_op    = '0;
    sif.cmd_rs1   = '0;
    sif.cmd_rs2   = '0;
    sif.cmd_rd    = '0;
    sif.rsp_ready = 1'b1;
    pl_all        = 1'b1;
    pl_one        = 1'b0;
    pl_addr       = '0;
    pl_data       = 8'h00;
    tick();
    pl_all = 1'b0;
    tick();

    // Reset state.
    $display("txn reset: checking reset values");
    chk("rst.cmd_ready", 32'(sif.cmd_ready), 32'd1);
    chk("rst.rsp_valid", 32'(sif.rsp_valid), 32'd0);
    chk("rst.rsp_data", 32'(sif.rsp_data), 32'd0);
    chk("rst.rsp_rd", 32'(sif.rsp_rd), 32'd0);
    chk("rst.we", 32'(rf_write_enabled), 32'd0);
    chk("rst.wr_addr", 32'(rf_write_addr), 32'd0);
    chk("rst.wr_bus", 32'(rf_write_bus), 32'd0);
    chk("rst.rd_addrs", 32'({rf_read_1_addr, rf_read_2_addr}), 32'd0);
    chk("rst.alu", 32'({alu_op, alu_a, alu_b}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Basic add: 0x12 + 0x05 -> reg7 = 0x17.
    preload(5'd3, 8'h12);
    preload(5'd4, 8'h05);
    do_op("add", 3'd0, 5'd3, 5'd4, 5'd7, 8'h12, 8'h05, 8'h17, 1'b1, 0);

    // Response held for 6 cycles: 0x3C ^ 0x0F = 0x33.
    preload(5'd1, 8'h3C);
    preload(5'd2, 8'h0F);
    do_op("hold", 3'd1, 5'd1, 5'd2, 5'd8, 8'h3C, 8'h0F, 8'h33, 1'b1, 6);

    // rd == rs1, then back-to-back read of the new value with rs1 == rs2.
    preload(5'd5, 8'h40);
    preload(5'd6, 8'h01);
    do_op("rd_eq_rs1", 3'd0, 5'd5, 5'd6, 5'd5, 8'h40, 8'h01, 8'h41, 1'b1, 0);
    do_op("b2b", 3'd0, 5'd5, 5'd5, 5'd9, 8'h41, 8'h41, 8'h82, 1'b1, 0);
    do_op("and", 3'd2, 5'd9, 5'd7, 5'd10, 8'h82, 8'h17, 8'h02, 1'b1, 0);

    // Clear with every register preloaded to 0xFF.
    pl_all  = 1'b1;
    pl_data = 8'hFF;
    tick();
    pl_all  = 1'b0;
    $display("txn clear: all registers from 0xFF to 0x00");
    chk("clr.idle_ready", 32'(sif.cmd_ready), 32'd1);
    sif.cmd_valid = 1'b1;
    sif.cmd_clr   = 1'b1;
    sif.cmd_op    = 3'd1;
    sif.cmd_rs1   = 5'd3;
    sif.cmd_rs2   = 5'd4;
    sif.cmd_rd    = 5'd6;
    sif.rsp_ready = 1'b1;
    tick();
    sif.cmd_valid = 1'b0;
    sif.cmd_clr   = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("clr.we", 32'(rf_write_enabled), 32'd1);
      chk("clr.addr", 32'(rf_write_addr), 32'(i));
      chk("clr.data", 32'(rf_write_bus), 32'd0);
      chk("clr.no_rsp", 32'(sif.rsp_valid), 32'd0);
      tick();
    end
    chk("clr.rsp_valid", 32'(sif.rsp_valid), 32'd1);
    chk("clr.rsp_data", 32'(sif.rsp_data), 32'd0);
    chk("clr.rsp_rd", 32'(sif.rsp_rd), 32'd31);
    chk("clr.no_we", 32'(rf_write_enabled), 32'd0);
    nz = 0;
    for (int i = 0; i < 32; i++) if (regs[i] !== 8'h00) nz++;
    chk("clr.nonzero_regs", 32'(nz), 32'd0);
    tick();
    chk("clr.back_idle", 32'(sif.cmd_ready), 32'd1);

    // Reset asserted during WRITE aborts the write.
    preload(5'd10, 8'h20);
    preload(5'd11, 8'h03);
    preload(5'd12, 8'h55);
    $display("txn reset_in_write: add r10+r11 -> r12 aborted");
    sif.cmd_valid = 1'b1;
    sif.cmd_op    = 3'd0;
    sif.cmd_rs1   = 5'd10;
    sif.cmd_rs2   = 5'd11;
    sif.cmd_rd    = 5'd12;
    tick();
    sif.cmd_valid = 1'b0;
    tick();
    tick();
    chk("rstw.we_before", 32'(rf_write_enabled), 32'd1);
    reset = 1'b0;
    #1;
    chk("rstw.we_dropped", 32'(rf_write_enabled), 32'd0);
    chk("rstw.cmd_ready", 32'(sif.cmd_ready), 32'd1);
    chk("rstw.rsp_valid", 32'(sif.rsp_valid), 32'd0);
    chk("rstw.rsp_data", 32'(sif.rsp_data), 32'd0);
    chk("rstw.wr_addr", 32'(rf_write_addr), 32'd0);
    chk("rstw.wr_bus", 32'(rf_write_bus), 32'd0);
    tick();
    chk("rstw.reg12_kept", 32'(regs[12]), 32'h55);
    @(negedge clk);
    reset = 1'b1;
    tick();
    do_op("after_rst", 3'd0, 5'd10, 5'd11, 5'd12, 8'h20, 8'h03, 8'h23, 1'b1, 0);

    // Register 0 behaviour.
    preload(5'd0, 8'hAA);
    preload(5'd4, 8'h05);
`ifdef RF_ZERO_REG_EN
    do_op("zero_reg", 3'd0, 5'd0, 5'd4, 5'd0, 8'h00, 8'h05, 8'h05, 1'b0, 0);
    chk("zero_reg.reg0_kept", 32'(regs[0]), 32'hAA);
`else
    do_op("reg0", 3'd0, 5'd0, 5'd4, 5'd0, 8'hAA, 8'h05, 8'hAF, 1'b1, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
